// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and overflow in one cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic            rsel_q, rsel_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_sgn, a_neg, b_neg;
  logic            in_dz, in_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shl, diff;
  logic            ge;
  logic [XLEN-1:0] quo_nx, rem_nx;

  // Final result: special cases override the signed magnitude result.
  function automatic logic [XLEN-1:0] fin(
    input logic            rsel,
    input logic            dz,
    input logic            ovf,
    input logic            qn,
    input logic            rn,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r
  );
    if (dz) return rsel ? a : '1;
    if (ovf) return rsel ? '0 : MINV;
    if (rsel) return rn ? -r : r;
    return qn ? -q : q;
  endfunction

  // Decode incoming operands into magnitudes and special-case flags.
  always_comb begin
    in_sgn = ~op[0];
    a_neg  = in_sgn & dividend[XLEN-1];
    b_neg  = in_sgn & divisor[XLEN-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    in_dz  = (divisor == '0);
    in_ovf = in_sgn & (dividend == MINV) & (divisor == '1);
  end

  // One restoring step on an XLEN+1-bit partial remainder.
  always_comb begin
    shl    = {rem_q, quo_q[XLEN-1]};
    diff   = shl - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], ge};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          rsel_d  = op[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = in_dz;
          ovf_d   = in_ovf;
          a_d     = dividend;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_EARLY_OUT_EN
          if (in_dz || in_ovf) begin
            state_d = DONE;
            res_d   = fin(op[1], in_dz, in_ovf, 1'b0, 1'b0,
                          dividend, '0, '0);
          end
`endif
        end
      end
      CALC: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = fin(rsel_q, dz_q, ovf_q, qneg_q, rneg_q,
                        a_q, quo_nx, rem_nx);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rsel_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Directed vectors; monitor checks result and done cycle.
module tb_div_unit;

  localparam int XLEN = 32;
  localparam int LAT  = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d actual=%h required=no done",
                 cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic int lat(input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return LAT;
`else
    if (o == 2'b00 && a == 32'h0 && b == 32'h0) return LAT;
    return LAT;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
    exp_t e;
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.res    = r;
    e.cyc    = cyc + 1 + lat(o, a, b);
    e.name   = nm;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout actual=no done required=done", sb[0].name);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    drain();
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    drain();
    tick();
    issue("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    drain();
    issue("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    drain();
    issue("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    drain();
    issue("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    drain();
    tick();
    issue("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    drain();
    issue("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
    drain();
    issue("div_m7_0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    drain();
    issue("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    drain();
    issue("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    drain();
    issue("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    drain();
    issue("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    drain();
    issue("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'hF);
    drain();
    issue("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    drain();
    issue("remu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000);
    drain();
    issue("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000);
    drain();

    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("result_hold", result, 32'hC000_0000);

    issue("divu_ignore", 2'b01, 32'd100, 32'd7, 32'd14);
    for (int k = 0; k < 32; k++) begin
      check("busy_calc", 32'(busy), 32'd1);
      if (k == 9) begin
        op       = 2'b00;
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
      end
      if (k == 10) start = 1'b0;
      tick();
    end
    check("ignore_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    tick();
    issue("divu_abort", 2'b01, 32'd100, 32'd7, 32'd14);
    repeat (14) tick();
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_result", result, 32'd0);

    issue("divu_recover", 2'b01, 32'd100, 32'd7, 32'd14);
    drain();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
